sysctrl_gen_wb: RTL and testbench

SYSCTRL_GEN_WB -- requirements
Module: sysctrl_gen_wb

---
 rtl/sysctrl_pkg.sv | 22 ++
 rtl/pwrgood_sync.sv | 30 +++
 rtl/sysctrl_gen_wb.sv | 122 ++++++++++++
 tb/tb_sysctrl_gen_wb.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/sysctrl_pkg.sv
// Shared register offsets, parameter limits and the latched-write record
// for the sysctrl Wishbone register block.
package sysctrl_pkg;

    localparam logic [7:0] OFF_PWRGOOD  = 8'h00;
    localparam logic [7:0] OFF_CLK_OUT  = 8'h04;
    localparam logic [7:0] OFF_TRAP_OUT = 8'h08;
    localparam logic [7:0] OFF_IRQ_SRC  = 8'h0C;
    localparam logic [7:0] OFF_PWR_EVT  = 8'h10;
    localparam logic [7:0] OFF_PWR_IEN  = 8'h14;

    localparam int N_MIN = 1;
    localparam int N_MAX = 8;

    // A claimed write is held here until the ack cycle ends, then committed.
    typedef struct packed {
        logic             we;
        logic [7:0]       off;
        logic [N_MAX-1:0] dat;
    } wr_req_t;

endpackage

// File: rtl/pwrgood_sync.sv
// One power-good channel: two-flop synchroniser plus a history flop that
// flags a synchronised 1->0 transition.
module pwrgood_sync (
    input  logic clk,
    input  logic rst,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);

    logic meta_q;
    logic sync_q;
    logic hist_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
            hist_q <= 1'b0;
        end else begin
            meta_q <= async_in;
            sync_q <= meta_q;
            hist_q <= sync_q;
        end
    end

    assign sync_out = sync_q;
    assign fall     = hist_q & ~sync_q;

endmodule

// File: rtl/sysctrl_gen_wb.sv
// System-control register block on a classic Wishbone slave port: routing
// selects, power-good status and sticky power-fail events with an interrupt.
module sysctrl_gen_wb
    import sysctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADR = 32'h2F00_0000,
    parameter int          N_PWR    = 4,
    parameter int          N_CLK    = 2,
    parameter int          N_IRQ    = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [31:0]      wb_dat_i,
    input  logic [31:0]      wb_adr_i,
    input  logic [3:0]       wb_sel_i,
    input  logic             wb_cyc_i,
    input  logic             wb_stb_i,
    input  logic             wb_we_i,
    output logic [31:0]      wb_dat_o,
    output logic             wb_ack_o,
    input  logic [N_PWR-1:0] pwrgood_i,
    output logic [N_CLK-1:0] clk_output_dest,
    output logic             trap_output_dest,
    output logic [N_IRQ-1:0] irq_inputsrc,
    output logic             pwr_irq_o
);

    localparam bit PARAMS_OK = (N_PWR >= N_MIN) && (N_PWR <= N_MAX) &&
                               (N_CLK >= N_MIN) && (N_CLK <= N_MAX) &&
                               (N_IRQ >= N_MIN) && (N_IRQ <= N_MAX);

    logic [N_PWR-1:0] pg_sync;
    logic [N_PWR-1:0] pg_fall;

    for (genvar i = 0; i < N_PWR; i++) begin : g_pwr
        pwrgood_sync u_sync (
            .clk      (wb_clk_i),
            .rst      (wb_rst_i),
            .async_in (pwrgood_i[i]),
            .sync_out (pg_sync[i]),
            .fall     (pg_fall[i])
        );
    end

    logic [N_CLK-1:0] clk_q;
    logic             trap_q;
    logic [N_IRQ-1:0] irq_src_q;
    logic [N_PWR-1:0] evt_q;
    logic [N_PWR-1:0] ien_q;
    wr_req_t          pend_q;

    logic             claim;
    logic             commit;
    logic [31:0]      rd_data;
    logic [N_PWR-1:0] evt_clr;

    assign claim  = wb_cyc_i & wb_stb_i & ~wb_ack_o &
                    (wb_adr_i[31:8] == BASE_ADR[31:8]);
    assign commit = wb_ack_o & pend_q.we;

    always_comb begin
        rd_data = '0;
        case (wb_adr_i[7:0])
            OFF_PWRGOOD:  rd_data[N_PWR-1:0] = pg_sync;
            OFF_CLK_OUT:  rd_data[N_CLK-1:0] = clk_q;
            OFF_TRAP_OUT: rd_data[0]         = trap_q;
            OFF_IRQ_SRC:  rd_data[N_IRQ-1:0] = irq_src_q;
            OFF_PWR_EVT:  rd_data[N_PWR-1:0] = evt_q;
            OFF_PWR_IEN:  rd_data[N_PWR-1:0] = ien_q;
            default:      rd_data = '0;
        endcase
    end

    always_comb begin
        evt_clr = '0;
        if (commit && pend_q.off == OFF_PWR_EVT) begin
            evt_clr = pend_q.dat[N_PWR-1:0];
        end
    end

    // New falling edges are OR-ed in after the clear so a coincident event wins.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wb_ack_o  <= 1'b0;
            wb_dat_o  <= '0;
            pend_q    <= '0;
            clk_q     <= '0;
            trap_q    <= 1'b0;
            irq_src_q <= '0;
            evt_q     <= '0;
            ien_q     <= '0;
            pwr_irq_o <= 1'b0;
        end else begin
            wb_ack_o <= claim;
            if (claim) begin
                wb_dat_o   <= rd_data;
                pend_q.we  <= wb_we_i & wb_sel_i[0];
                pend_q.off <= wb_adr_i[7:0];
                pend_q.dat <= wb_dat_i[N_MAX-1:0];
            end
            if (commit) begin
                case (pend_q.off)
                    OFF_CLK_OUT:  clk_q     <= pend_q.dat[N_CLK-1:0];
                    OFF_TRAP_OUT: trap_q    <= pend_q.dat[0];
                    OFF_IRQ_SRC:  irq_src_q <= pend_q.dat[N_IRQ-1:0];
                    OFF_PWR_IEN:  ien_q     <= pend_q.dat[N_PWR-1:0];
                    default: ;
                endcase
            end
            evt_q     <= (evt_q & ~evt_clr) | pg_fall;
            pwr_irq_o <= |(evt_q & ien_q);
        end
    end

    assign clk_output_dest  = clk_q;
    assign trap_output_dest = trap_q;
    assign irq_inputsrc     = irq_src_q;

    logic unused_ok;
    assign unused_ok = ^{wb_dat_i[31:N_MAX], wb_sel_i[3:1], pend_q.dat, PARAMS_OK};

endmodule

// File: tb/tb_sysctrl_gen_wb.sv
// Self-checking bench for sysctrl_gen_wb: directed scenarios with literal
// expectations, then random traffic against a cycle-level behavioural model.
module tb_sysctrl_gen_wb;

    localparam logic [31:0] BASE = 32'h2F00_0000;
    localparam int NP = 4;
    localparam int NC = 2;
    localparam int NI = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   dat_i;
    logic [31:0]   adr_i;
    logic [3:0]    sel;
    logic          cyc;
    logic          stb;
    logic          we;
    logic [31:0]   dat_o;
    logic          ack;
    logic [NP-1:0] pg;
    logic [NC-1:0] clkd;
    logic          trapd;
    logic [NI-1:0] irqs;
    logic          pirq;

    int vectors     = 0;
    int miscompares = 0;
    bit cmpOn       = 1'b0;

    always #5 clk = ~clk;

    sysctrl_gen_wb #(
        .BASE_ADR (BASE),
        .N_PWR    (NP),
        .N_CLK    (NC),
        .N_IRQ    (NI)
    ) dut (
        .wb_clk_i         (clk),
        .wb_rst_i         (rst),
        .wb_dat_i         (dat_i),
        .wb_adr_i         (adr_i),
        .wb_sel_i         (sel),
        .wb_cyc_i         (cyc),
        .wb_stb_i         (stb),
        .wb_we_i          (we),
        .wb_dat_o         (dat_o),
        .wb_ack_o         (ack),
        .pwrgood_i        (pg),
        .clk_output_dest  (clkd),
        .trap_output_dest (trapd),
        .irq_inputsrc     (irqs),
        .pwr_irq_o        (pirq)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Behavioural model: register contents, outstanding write and a history
    // of power-good samples (index 0 = sampled at the previous edge).
    logic          m_ack = 0, m_inRst = 1, m_trap = 0, m_pirq = 0, p_we = 0;
    logic [31:0]   m_dat = 0, p_dat = 0;
    logic [7:0]    p_off = 0;
    logic [NC-1:0] m_clk = 0;
    logic [NI-1:0] m_irqs = 0;
    logic [NP-1:0] m_evt = 0, m_ien = 0;
    logic [NP-1:0] pgLog[$] = '{'0, '0, '0};

    function automatic logic [31:0] modelRead(input logic [7:0] off);
        case (off)
            8'h00:   return 32'(pgLog[1]);
            8'h04:   return 32'(m_clk);
            8'h08:   return 32'(m_trap);
            8'h0C:   return 32'(m_irqs);
            8'h10:   return 32'(m_evt);
            8'h14:   return 32'(m_ien);
            default: return 32'h0;
        endcase
    endfunction

    always @(posedge clk) begin : model
        logic [NP-1:0] fall, clr;
        logic [31:0]   rd;
        logic          claim, oldIrq;
        m_inRst = rst;
        if (rst) begin
            m_ack = 0; m_dat = 0; m_clk = 0; m_trap = 0; m_irqs = 0;
            m_evt = 0; m_ien = 0; m_pirq = 0; p_we = 0;
            pgLog = '{'0, '0, '0};
        end else begin
            claim  = cyc && stb && !m_ack && (adr_i[31:8] == BASE[31:8]);
            rd     = modelRead(adr_i[7:0]);
            oldIrq = |(m_evt & m_ien);
            fall   = pgLog[2] & ~pgLog[1];
            clr    = '0;
            if (m_ack && p_we) begin
                case (p_off)
                    8'h04: m_clk  = p_dat[NC-1:0];
                    8'h08: m_trap = p_dat[0];
                    8'h0C: m_irqs = p_dat[NI-1:0];
                    8'h10: clr    = p_dat[NP-1:0];
                    8'h14: m_ien  = p_dat[NP-1:0];
                    default: ;
                endcase
            end
            m_evt  = (m_evt & ~clr) | fall;
            m_pirq = oldIrq;
            if (claim) begin
                m_dat = rd;
                p_we  = we && sel[0];
                p_off = adr_i[7:0];
                p_dat = dat_i;
            end
            m_ack = claim;
            pgLog.push_front(pg);
            void'(pgLog.pop_back());
        end
    end

    // Compare DUT against the model every cycle, a little after the edge.
    always @(posedge clk) begin
        #2;
        if (cmpOn) begin
            checkOutput("ack", 32'(ack), 32'(m_ack));
            if (m_ack || m_inRst) checkOutput("rdata", dat_o, m_dat);
            checkOutput("clk_dest", 32'(clkd), 32'(m_clk));
            checkOutput("trap_dest", 32'(trapd), 32'(m_trap));
            checkOutput("irq_src", 32'(irqs), 32'(m_irqs));
            checkOutput("pwr_irq", 32'(pirq), 32'(m_pirq));
        end
    end

    // Drives one request from a negedge and waits a bounded time for its ack.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                                 input logic w, input int maxWait,
                                 output logic gotAck, output logic [31:0] rdata, output int lat);
        @(negedge clk);
        adr_i = a; dat_i = d; sel = s; we = w; cyc = 1; stb = 1;
        gotAck = 0; rdata = 'x; lat = 0;
        for (int i = 1; i <= maxWait; i++) begin
            @(negedge clk);
            if (ack) begin
                gotAck = 1; rdata = dat_o; lat = i;
                break;
            end
        end
        cyc = 0; stb = 0; we = 0;
    endtask

    logic        ga;
    logic [31:0] rd;
    int          lat;
    logic [5:0]  pattern;

    initial begin
        rst = 1; pg = '1; cyc = 0; stb = 0; we = 0; sel = 0; adr_i = 0; dat_i = 0;
        repeat (3) @(negedge clk);
        cmpOn = 1;
        checkOutput("rst_ack", 32'(ack), 0);
        checkOutput("rst_dat", dat_o, 0);
        checkOutput("rst_clk", 32'(clkd), 0);
        checkOutput("rst_trap", 32'(trapd), 0);
        checkOutput("rst_pirq", 32'(pirq), 0);
        rst = 0;
        repeat (5) @(negedge clk);

        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("evt_after_rst", rd, 0);
        applyStimulus(BASE + 32'h00, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("pwrgood_rd", rd, 32'hF);

        applyStimulus(BASE + 32'h04, 32'h3, 4'h1, 1, 16, ga, rd, lat);
        checkOutput("clk_wr_lat", 32'(lat), 1);
        checkOutput("clk_during_ack", 32'(clkd), 0);
        @(negedge clk);
        checkOutput("clk_after_ack", 32'(clkd), 32'h3);
        applyStimulus(BASE + 32'h04, 32'h0, 4'h2, 1, 16, ga, rd, lat);
        checkOutput("sel2_acked", 32'(ga), 1);
        @(negedge clk);
        checkOutput("sel2_nochange", 32'(clkd), 32'h3);

        applyStimulus(BASE + 32'h20, 32'h0, 4'hF, 0, 16, ga, rd, lat);
        checkOutput("unmapped_ack", 32'(ga), 1);
        checkOutput("unmapped_dat", rd, 0);
        applyStimulus(32'h3000_0004, 32'h1, 4'h1, 1, 16, ga, rd, lat);
        checkOutput("foreign_noack", 32'(ga), 0);

        applyStimulus(BASE + 32'h14, 32'h1, 4'h1, 1, 16, ga, rd, lat);
        @(negedge clk);
        pg[0] = 0;
        repeat (3) @(negedge clk);
        checkOutput("irq_cycle3", 32'(pirq), 0);
        @(negedge clk);
        checkOutput("irq_cycle4", 32'(pirq), 1);
        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("evt_set", rd, 32'h1);
        applyStimulus(BASE + 32'h00, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("pwrgood_drop", rd, 32'hE);
        applyStimulus(BASE + 32'h10, 32'h1, 4'h1, 1, 16, ga, rd, lat);
        repeat (2) @(negedge clk);
        checkOutput("irq_cleared", 32'(pirq), 0);
        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("evt_cleared", rd, 0);

        pg[2] = 0;
        applyStimulus(BASE + 32'h10, 32'h4, 4'h1, 1, 16, ga, rd, lat);
        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("set_beats_clr", rd, 32'h4);
        applyStimulus(BASE + 32'h10, 32'h4, 4'h1, 1, 16, ga, rd, lat);
        pg = '1;
        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("evt2_cleared", rd, 0);

        @(negedge clk);
        adr_i = BASE; we = 0; sel = 4'h1; cyc = 1; stb = 1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            pattern[k] = ack;
        end
        cyc = 0; stb = 0;
        checkOutput("held_stb_acks", 32'(pattern), 32'h15);

        @(negedge clk);
        adr_i = BASE + 32'h08; dat_i = 32'h1; sel = 4'h1; we = 1; cyc = 1; stb = 1; rst = 1;
        @(negedge clk);
        checkOutput("rst_abort_ack", 32'(ack), 0);
        cyc = 0; stb = 0; we = 0;
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        checkOutput("rst_abort_trap", 32'(trapd), 0);
        repeat (6) @(negedge clk);
        applyStimulus(BASE + 32'h10, 0, 4'h1, 0, 16, ga, rd, lat);
        checkOutput("no_false_evt", rd, 0);

        for (int t = 0; t < 300; t++) begin
            int k, hold;
            if ($urandom_range(0, 99) < 3) begin
                @(negedge clk);
                rst = 1;
                repeat ($urandom_range(1, 2)) @(negedge clk);
                rst = 0;
            end
            k = $urandom_range(0, 9);
            @(negedge clk);
            case (k)
                6:       adr_i = BASE + 32'h20;
                7:       adr_i = BASE + 32'($urandom_range(0, 255));
                8:       adr_i = 32'h3000_0000 | 32'($urandom_range(0, 5) * 4);
                9:       adr_i = BASE + 32'h10;
                default: adr_i = BASE + 32'(k * 4);
            endcase
            dat_i = $urandom;
            sel   = 4'($urandom_range(0, 15));
            we    = 1'($urandom_range(0, 1));
            cyc   = 1;
            stb   = ($urandom_range(0, 7) != 0);
            hold  = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                if ($urandom_range(0, 3) == 0) pg[$urandom_range(0, NP - 1)] ^= 1'b1;
                @(negedge clk);
            end
            cyc = 0; stb = 0; we = 0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
